multiplier_2x3: RTL and testbench
=================================

MULTIPLIER_2X3 -- requirements
Module: multiplier_2x3

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: M_W=2, Q_W=3, P_W=5.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 m  input  2  unsigned multiplicand.
REQ-005 q  input  3  unsigned multiplier.
REQ-006 in_valid  input  1  qualifies m/q for the registered path.
REQ-007 p  output  5  combinational unsigned product m*q.
REQ-008 p_reg  output  5  registered product of the last accepted operands.
REQ-009 out_valid  output  1  high one cycle after an accepted in_valid.

Function
REQ-010 p SHALL equal m*q, unsigned, zero latency, for every one of the 32 input combinations; no clock or reset dependence.
REQ-011 The product SHALL be computed as a 2x3 array: pp0 = q AND m[0], pp1 = q AND m[1] weighted by 2; p[0] = pp0[0]; p[4:1] from a ripple chain of one half adder plus full adders over pp0[2:1], pp1[2:0] and carries.
REQ-012 The block SHALL NOT use the "*" operator for p or p_reg; the array of REQ-011 is the only arithmetic.
REQ-013 Maximum product 3*7=21 (5'b10101) SHALL fit in 5 bits; no overflow or truncation path exists.
REQ-014 On a rising clk edge with in_valid=1, p_reg SHALL load the array result for the current m/q; latency exactly 1 cycle.
REQ-015 On a rising clk edge with in_valid=0, p_reg SHALL hold its value.
REQ-016 out_valid SHALL be the registered copy of in_valid: 1 the cycle after in_valid=1, 0 the cycle after in_valid=0.
REQ-017 Back-to-back in_valid SHALL be accepted every cycle; no backpressure or ready signal exists.
REQ-018 X or changing m/q while in_valid=0 SHALL NOT affect p_reg or out_valid.

Reset
REQ-019 rst_n=0 SHALL immediately, without a clock edge, force p_reg=5'd0 and out_valid=0.
REQ-020 While rst_n=0, in_valid SHALL be ignored; p SHALL keep tracking m*q.
REQ-021 Reset asserted mid-operation SHALL discard the pending result; the first edge after release with in_valid=1 SHALL load normally.
REQ-022 rst_n SHALL be deasserted synchronously to clk by the surrounding system; the block adds no synchronizer.

Structure
REQ-023 A shared package SHALL hold the width constants M_W=2, Q_W=3, P_W=5.
REQ-024 One sub-module full_adder (a, b, cin -> sum, cout) SHALL be instantiated for each adder cell; a half adder is a full_adder with cin tied to 0.
REQ-025 The combinational array SHALL feed both p and the p_reg D input; it SHALL NOT be duplicated.

Verification
REQ-026 Exhaustive: m=0..3, q=0..7, 10 ns apart -> p==m*q for all 32 pairs (e.g. m=2, q=5 -> p=10).
REQ-027 Corners: m=3, q=7 -> p=21; m=0, q=7 -> p=0; m=3, q=0 -> p=0; m=1, q=6 -> p=6.
REQ-028 Latency: in_valid=1 with m=2, q=3 at edge N -> p_reg=6, out_valid=1 after edge N; in_valid=0 at edge N+1 -> p_reg holds 6, out_valid=0.
REQ-029 Streaming: in_valid=1 for 3 cycles with (1,7), (3,5), (2,2) -> p_reg sequence 7, 15, 4 on consecutive cycles; out_valid stays 1.
REQ-030 Async reset: p_reg=21, out_valid=1, drop rst_n between edges -> both 0 immediately, p still equals m*q; release, in_valid=1, m=1, q=3 -> p_reg=3 one cycle later.

Source files
------------

// File: rtl/multiplier_2x3_pkg.sv
// Shared widths for the 2x3 array multiplier.
// Imported by every file of this block.
package multiplier_2x3_pkg;

    localparam int M_W = 2;
    localparam int Q_W = 3;
    localparam int P_W = 5;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell of the multiplier array.
// A half adder is this cell with cin tied low.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and majority carry of the three inputs.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/multiplier_2x3.sv
// Unsigned 2x3 array multiplier with combinational product
// and a registered, valid-qualified copy of it.
module multiplier_2x3
    import multiplier_2x3_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M_W-1:0] m,
    input  logic [Q_W-1:0] q,
    input  logic           in_valid,
    output logic [P_W-1:0] p,
    output logic [P_W-1:0] p_reg,
    output logic           out_valid
);

    logic [Q_W-1:0] pp0;
    logic [Q_W-1:0] pp1;
    logic           s1, c1;
    logic           s2, c2;
    logic           s3, c3;
    logic [P_W-1:0] p_reg_d, p_reg_q;
    logic           out_valid_d, out_valid_q;

    // Partial products: pp1 carries weight 2.
    always_comb begin
        pp0 = q & {Q_W{m[0]}};
        pp1 = q & {Q_W{m[1]}};
    end

    // Bit 1: half adder.
    full_adder u_fa1 (
        .a    (pp0[1]),
        .b    (pp1[0]),
        .cin  (1'b0),
        .sum  (s1),
        .cout (c1)
    );

    // Bit 2: full adder absorbing the bit-1 carry.
    full_adder u_fa2 (
        .a    (pp0[2]),
        .b    (pp1[1]),
        .cin  (c1),
        .sum  (s2),
        .cout (c2)
    );

    // Bit 3: top partial product plus ripple carry.
    full_adder u_fa3 (
        .a    (pp1[2]),
        .b    (c2),
        .cin  (1'b0),
        .sum  (s3),
        .cout (c3)
    );

    // Assemble the product; it also feeds the register input.
    always_comb begin
        p = {c3, s3, s2, s1, pp0[0]};
    end

    // Load on valid, otherwise hold.
    always_comb begin
        p_reg_d     = p_reg_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_reg_d = p;
        end
    end

    // Result and valid registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_reg_q     <= p_reg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p_reg     = p_reg_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_2x3.sv
// Directed bench for multiplier_2x3: exhaustive product,
// register latency, streaming and async reset.
module tb_multiplier_2x3;

    logic       clk;
    logic       rst_n;
    logic [1:0] m;
    logic [2:0] q;
    logic       in_valid;
    logic [4:0] p;
    logic [4:0] p_reg;
    logic       out_valid;

    int n_checks;
    int n_fail;

    multiplier_2x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m         (m),
        .q         (q),
        .in_valid  (in_valid),
        .p         (p),
        .p_reg     (p_reg),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk5(input string tag, input logic [4:0] obs,
                        input logic [4:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs,
                        input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_p;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        m        = 2'd3;
        q        = 3'd7;

        // Reset state, with in_valid high and edges occurring.
        edge_sample();
        edge_sample();
        chk5("reset_p_reg", p_reg, 5'd0);
        chk1("reset_out_valid", out_valid, 1'b0);

        // Exhaustive combinational product while held in reset.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                m = i[1:0];
                q = j[2:0];
                #10;
                exp_p = 5'(i * j);
                chk5($sformatf("p_%0dx%0d", i, j), p, exp_p);
            end
        end
        chk5("reset_hold_p_reg", p_reg, 5'd0);
        chk1("reset_hold_out_valid", out_valid, 1'b0);

        // Release reset away from the clock edge.
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Corner products.
        m = 2'd3; q = 3'd7; #1; chk5("corner_3x7", p, 5'd21);
        m = 2'd0; q = 3'd7; #1; chk5("corner_0x7", p, 5'd0);
        m = 2'd3; q = 3'd0; #1; chk5("corner_3x0", p, 5'd0);
        m = 2'd1; q = 3'd6; #1; chk5("corner_1x6", p, 5'd6);
        m = 2'd2; q = 3'd5; #1; chk5("corner_2x5", p, 5'd10);

        // Latency: load 2x3, then hold with in_valid low.
        @(negedge clk);
        m = 2'd2; q = 3'd3; in_valid = 1'b1;
        edge_sample();
        chk5("lat_p_reg", p_reg, 5'd6);
        chk1("lat_out_valid", out_valid, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; m = 2'd3; q = 3'd7;
        edge_sample();
        chk5("hold_p_reg", p_reg, 5'd6);
        chk1("hold_out_valid", out_valid, 1'b0);
        @(negedge clk);
        m = 2'bxx; q = 3'bxxx;
        edge_sample();
        chk5("hold_x_p_reg", p_reg, 5'd6);
        chk1("hold_x_out_valid", out_valid, 1'b0);

        // Streaming three operands back to back.
        @(negedge clk);
        m = 2'd1; q = 3'd7; in_valid = 1'b1;
        edge_sample();
        chk5("stream0_p_reg", p_reg, 5'd7);
        chk1("stream0_out_valid", out_valid, 1'b1);
        @(negedge clk);
        m = 2'd3; q = 3'd5;
        edge_sample();
        chk5("stream1_p_reg", p_reg, 5'd15);
        chk1("stream1_out_valid", out_valid, 1'b1);
        @(negedge clk);
        m = 2'd2; q = 3'd2;
        edge_sample();
        chk5("stream2_p_reg", p_reg, 5'd4);
        chk1("stream2_out_valid", out_valid, 1'b1);

        // Async reset mid-operation.
        @(negedge clk);
        m = 2'd3; q = 3'd7;
        edge_sample();
        chk5("pre_rst_p_reg", p_reg, 5'd21);
        chk1("pre_rst_out_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk5("async_p_reg", p_reg, 5'd0);
        chk1("async_out_valid", out_valid, 1'b0);
        chk5("async_p", p, 5'd21);
        edge_sample();
        chk5("in_rst_p_reg", p_reg, 5'd0);
        chk1("in_rst_out_valid", out_valid, 1'b0);

        // Release and load normally.
        @(negedge clk);
        rst_n = 1'b1;
        m = 2'd1; q = 3'd3; in_valid = 1'b1;
        edge_sample();
        chk5("post_rst_p_reg", p_reg, 5'd3);
        chk1("post_rst_out_valid", out_valid, 1'b1);

        @(negedge clk);
        in_valid = 1'b0;
        edge_sample();
        chk1("final_out_valid", out_valid, 1'b0);
        chk5("final_p_reg", p_reg, 5'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
